// File: rtl/usb_warmboot_ctrl.sv
// Bootloader exit sequencer: USB detach, settle interval, then warm-boot into the latched image.
// USB_WARMBOOT_DETACH_EN enables the D+ pull-up detach phase; when undefined, the sequence goes straight to SETTLE.
module usb_warmboot_ctrl #(
  parameter int unsigned DETACH_CYCLES = 480000,
  parameter int unsigned SETTLE_CYCLES = 48
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] image_sel,
  output logic       usb_pu,
  output logic       usb_detach,
  output logic       warmboot_boot,
  output logic [1:0] warmboot_s,
  output logic       busy
);

  // state  | meaning
  // IDLE   | attached, waiting for boot_req
  // DETACH | pull-up off, PHY forced to SE0
  // SETTLE | PHY released, image select held stable
  // BOOT   | warm-boot asserted, left only by reset
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef USB_WARMBOOT_DETACH_EN
    S_DETACH = 2'd1,
`endif
    S_SETTLE = 2'd2,
    S_BOOT   = 2'd3
  } state_t;

  localparam logic [19:0] DETACH_LOAD = 20'(DETACH_CYCLES - 1);
  localparam logic [19:0] SETTLE_LOAD = 20'(SETTLE_CYCLES - 1);

  state_t      r_state;
  logic [19:0] r_cnt;
  logic        r_pu;
  logic        r_boot;
  logic [1:0]  r_sel;
  logic        r_busy;

`ifdef USB_WARMBOOT_DETACH_EN
  logic        r_detach;
  assign usb_detach = r_detach;
`else
  logic        w_unused_detach;
  assign w_unused_detach = ^DETACH_LOAD;
  assign usb_detach      = 1'b0;
`endif

  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pu     <= 1'b1;
      r_boot   <= 1'b0;
      r_sel    <= 2'b00;
      r_busy   <= 1'b0;
`ifdef USB_WARMBOOT_DETACH_EN
      r_detach <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (boot_req) begin
            r_sel  <= image_sel;
            r_busy <= 1'b1;
`ifdef USB_WARMBOOT_DETACH_EN
            r_state  <= S_DETACH;
            r_cnt    <= DETACH_LOAD;
            r_pu     <= 1'b0;
            r_detach <= 1'b1;
`else
            r_state <= S_SETTLE;
            r_cnt   <= SETTLE_LOAD;
`endif
          end
        end
`ifdef USB_WARMBOOT_DETACH_EN
        S_DETACH: begin
          if (r_cnt == 20'd0) begin
            r_state  <= S_SETTLE;
            r_cnt    <= SETTLE_LOAD;
            r_detach <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 20'd1;
          end
        end
`endif
        S_SETTLE: begin
          if (r_cnt == 20'd0) begin
            r_state <= S_BOOT;
            r_boot  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 20'd1;
          end
        end
        S_BOOT: begin
          r_state <= S_BOOT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign usb_pu        = r_pu;
  assign warmboot_boot = r_boot;
  assign warmboot_s    = r_sel;
  assign busy          = r_busy;

endmodule

// File: tb/tb_usb_warmboot_ctrl.sv
// Randomized scoreboard bench for usb_warmboot_ctrl; expected outputs come from a
// cycles-since-trigger model, honouring USB_WARMBOOT_DETACH_EN when defined.
module tb_usb_warmboot_ctrl;

  localparam int D = 10;
  localparam int S = 4;
`ifdef USB_WARMBOOT_DETACH_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       boot_req = 1'b0;
  logic [1:0] image_sel = 2'b00;
  logic       usb_pu, usb_detach, warmboot_boot, busy;
  logic [1:0] warmboot_s;

  usb_warmboot_ctrl #(.DETACH_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .clk_48mhz    (clk),
    .reset        (rst_n),
    .boot_req     (boot_req),
    .image_sel    (image_sel),
    .usb_pu       (usb_pu),
    .usb_detach   (usb_detach),
    .warmboot_boot(warmboot_boot),
    .warmboot_s   (warmboot_s),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pu;
    logic       det;
    logic       boot;
    logic [1:0] s;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: everything follows from how many edges have passed since the trigger.
  bit         m_trig = 1'b0;
  int         m_k = 0;
  logic [1:0] m_sel = 2'b00;

  function automatic obs_t reset_obs();
    obs_t o;
    o = {1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    return o;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    if (!m_trig) return reset_obs();
    o.busy = 1'b1;
    o.s    = m_sel;
    o.pu   = EN ? 1'b0 : 1'b1;
    o.det  = EN && (m_k < D);
    o.boot = EN ? (m_k >= D + S) : (m_k >= S);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {usb_pu, usb_detach, warmboot_boot, warmboot_s, busy};
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got pu=%b det=%b boot=%b s=%b busy=%b, expected pu=%b det=%b boot=%b s=%b busy=%b",
               name, $time, act.pu, act.det, act.boot, act.s, act.busy,
               exp.pu, exp.det, exp.boot, exp.s, exp.busy);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_trig = 1'b0;
      m_k    = 0;
      m_sel  = 2'b00;
    end else if (!m_trig) begin
      if (boot_req) begin
        m_trig = 1'b1;
        m_k    = 0;
        m_sel  = image_sel;
      end
    end else if (m_k < 1000) begin
      m_k++;
    end
    exp_q.push_back(model_out());
  end

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check("cycle", dut_obs(), exp_q.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_obs(), reset_obs());
  endtask

  initial begin
    int len, rp;
    bit do_rst;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (100) step();

    for (int run = 0; run < 12; run++) begin
      image_sel = (run == 0) ? 2'b10 : 2'($urandom);
      boot_req  = 1'b1;
      step();
      len    = D + S + 5 + $urandom_range(0, 45);
      do_rst = (run % 3 == 2);
      rp     = $urandom_range(1, D + S);
      for (int c = 0; c < len; c++) begin
        if (run == 0) begin
          boot_req  = 1'b0;
          image_sel = 2'b10;
        end else begin
          boot_req  = 1'($urandom_range(0, 1));
          image_sel = 2'($urandom);
        end
        if (do_rst && c == rp) begin
          async_reset();
          boot_req  = 1'b1;
          image_sel = 2'($urandom);
          step();
          step();
          rst_n = 1'b1;
        end
        step();
      end
      async_reset();
      boot_req = 1'($urandom_range(0, 1));
      step();
      rst_n = 1'b1;
      repeat ($urandom_range(0, 5)) step();
    end

    boot_req = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected values still queued, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_warmboot_ctrl.md
# usb_warmboot_ctrl

Sequences the exit from the bootloader to the user configuration. It consumes the `boot` request produced by the USB bootloader top level. It then detaches from the bus by dropping the D+ pull-up for a fixed interval, so the host sees a clean disconnect. Finally it drives the device's warm-boot primitive pins with a latched image select. It sits between the bootloader's `boot` output and the SB_WARMBOOT-style primitive instantiated in the board top.

## Interface
Parameters:
- `DETACH_CYCLES`, default 480000: cycles the pull-up is held off (10 ms at 48 MHz). Legal range 1 to 2^20-1.
- `SETTLE_CYCLES`, default 48: cycles between re-driving idle and asserting warm-boot. Legal range 1 to 2^20-1.

Ports:
- `clk_48mhz`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `boot_req`, in, 1: level request from the bootloader (host timeout or boot command).
- `image_sel`, in, 2: image number; sampled on the trigger cycle only.
- `usb_pu`, out, 1: D+ pull-up enable; 1 = attached.
- `usb_detach`, out, 1: forces the USB PHY tx to SE0/idle-low while high.
- `warmboot_boot`, out, 1: warm-boot trigger pin.
- `warmboot_s`, out, 2: warm-boot image select pins.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - `usb_pu`=1
  - `usb_detach`=0
  - `warmboot_boot`=0
  - `warmboot_s`=2'b00
  - `busy`=0
  - state=IDLE
  - counter=0
- The FSM has four states: IDLE, DETACH, SETTLE, BOOT.
- IDLE:
  - Outputs stay at their reset values.
  - When `boot_req`=1 on a rising clock edge, latch `image_sel` into `warmboot_s`, load the counter with `DETACH_CYCLES-1`, and go to DETACH.
- DETACH:
  - `usb_pu`=0, `usb_detach`=1, `busy`=1.
  - Decrement the counter each cycle.
  - At counter==0, load `SETTLE_CYCLES-1` and go to SETTLE.
- SETTLE:
  - `usb_pu` stays 0; `usb_detach`=0, so the PHY output returns to undriven.
  - Decrement the counter.
  - At counter==0, go to BOOT.
- BOOT:
  - `warmboot_boot`=1, `usb_pu`=0, `busy`=1.
  - Terminal: the block leaves BOOT only on `reset`.
- Once the block has left IDLE, `boot_req` and `image_sel` are ignored. A request that deasserts mid-sequence does not abort it.
- `warmboot_s` holds its latched value from the trigger until reset. It is stable for at least `SETTLE_CYCLES` cycles before `warmboot_boot` rises.
- The counter is a 20-bit down-counter. No wrap is possible, because a load always precedes counting.
- Parameter values out of range are a configuration error and need not be checked in RTL.
- Reset asserted in any state immediately forces all reset values, including `usb_pu`=1 and `warmboot_boot`=0.

## Timing
- Trigger latency: `boot_req` sampled high at edge N gives `usb_pu`=0, `usb_detach`=1 and `busy`=1 after edge N.
- `usb_detach` stays high for exactly `DETACH_CYCLES` cycles.
- SETTLE lasts exactly `SETTLE_CYCLES` cycles.
- `warmboot_boot` rises after edge N+`DETACH_CYCLES`+`SETTLE_CYCLES` and stays high.
- `image_sel` is sampled only at edge N. Changes at N+1 onward have no effect.
- Reset deassertion takes effect asynchronously. The first trigger is possible on the first edge after release.
- A `boot_req` already high at reset release triggers on the first edge.

## Configuration
- `USB_WARMBOOT_DETACH_EN` defined:
  - Full sequence as above.
- `USB_WARMBOOT_DETACH_EN` not defined:
  - The DETACH state is not compiled.
  - IDLE goes directly to SETTLE, loading `SETTLE_CYCLES-1`.
  - `usb_detach` is tied to 0 and `usb_pu` stays 1 in all states.
  - `DETACH_CYCLES` is unused.
  - `warmboot_boot` rises after edge N+`SETTLE_CYCLES`.

## Test plan
Parameters `DETACH_CYCLES`=10 and `SETTLE_CYCLES`=4 are used unless noted.
- Reset check: release `reset`, hold `boot_req`=0 for 100 cycles -> `usb_pu`=1, `usb_detach`=0, `warmboot_boot`=0, `busy`=0 throughout.
- Basic sequence: pulse `boot_req` for 1 cycle at edge N with `image_sel`=2'b10 -> `usb_detach` high for exactly 10 cycles; `warmboot_boot` high from N+14 onward; `warmboot_s`=2'b10 from N+1 onward.
- Late inputs ignored: trigger with `image_sel`=2'b01, then change it to 2'b11 and drop `boot_req` at N+3 -> `warmboot_s` stays 2'b01 and the sequence completes unchanged.
- Mid-sequence reset: assert `reset`=0 at N+5 (in DETACH) -> asynchronously `usb_pu`=1, `usb_detach`=0, `busy`=0; after release with `boot_req`=1, the sequence restarts with a full 10-cycle detach.
- Terminal state: after BOOT, toggle `boot_req` for 50 cycles -> `warmboot_boot` stays 1 and `usb_pu` stays 0.
- Macro undefined: trigger at N -> `usb_pu` stays 1, `usb_detach` stays 0, `warmboot_boot` rises at N+4.
